// File: rtl/gemm_stream_sequencer.sv
// rtl/gemm_stream_sequencer.sv - Row stream sequencer, tag pipeline and result FIFO for the GEMM systolic core
package gemm_seq_pkg;
    typedef enum logic [1:0] {
        CMD_NONE          = 2'd0,
        CMD_WRITE_WEIGHTS = 2'd1,
        CMD_STREAM        = 2'd2
    } command_t;
endpackage

module gemm_stream_sequencer
    import gemm_seq_pkg::*;
#(
    parameter int SA_SIZE    = 4,
    parameter int ACT_W      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SA_SIZE-1:0][ACT_W-1:0] in_data,
    input  logic                          in_last,
    input  logic                          wload_valid,
    output logic                          wload_ready,
    output command_t                      gemm_cmd,
    output logic [SA_SIZE-1:0][ACT_W-1:0] gemm_act_in,
    input  logic [SA_SIZE-1:0][ACT_W-1:0] gemm_act_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SA_SIZE-1:0][ACT_W-1:0] out_data,
    output logic                          out_last,
    output logic                          job_done,
    output logic                          busy
);
    localparam int LAT = 2 * SA_SIZE - 1;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + LAT + 2);

    // Stage i of the tag pipeline tracks a row that entered the core i edges ago.
    logic [LAT:0]                  tag_v_q, tag_v_d;
    logic [LAT:0]                  tag_l_q, tag_l_d;
    logic [SA_SIZE-1:0][ACT_W-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]         mem_last_q;
    logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                 count_q, count_d;
    logic [CW-1:0]                 tags_cnt;
    logic                          accept;
    logic                          push;
    logic                          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Count rows in flight; each one holds a reserved FIFO slot (credit).
    always_comb begin
        tags_cnt = '0;
        for (int i = 0; i <= LAT; i++) begin
            tags_cnt = tags_cnt + CW'(tag_v_q[i]);
        end
    end

    // Handshakes, core command and bubble insertion; nothing is granted while in reset.
    always_comb begin
        in_ready    = resetn && !wload_valid && ((count_q + tags_cnt) < CW'(FIFO_DEPTH));
        accept      = in_valid && in_ready;
        wload_ready = resetn && wload_valid && (tag_v_q == '0);
        if (wload_ready) begin
            gemm_cmd = CMD_WRITE_WEIGHTS;
        end else if (accept || (|tag_v_q[LAT-1:0])) begin
            gemm_cmd = CMD_STREAM;
        end else begin
            gemm_cmd = CMD_NONE;
        end
        gemm_act_in = accept ? in_data : '0;
        push        = tag_v_q[LAT];
        out_valid   = (count_q != '0);
        pop         = out_valid && out_ready;
        out_data    = mem_q[rd_ptr_q];
        out_last    = out_valid && mem_last_q[rd_ptr_q];
        job_done    = pop && out_last;
        busy        = (|tag_v_q) || out_valid;
    end

    // Next state of the tag pipeline and FIFO bookkeeping.
    always_comb begin
        tag_v_d  = {tag_v_q[LAT-1:0], accept};
        tag_l_d  = {tag_l_q[LAT-1:0], accept && in_last};
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // State registers; reset wipes tags and FIFO contents so nothing stale survives.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tag_v_q    <= '0;
            tag_l_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            mem_last_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            assert (!(push && !pop && (count_q == CW'(FIFO_DEPTH))));
            tag_v_q  <= tag_v_d;
            tag_l_q  <= tag_l_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q]      <= gemm_act_out;
                mem_last_q[wr_ptr_q] <= tag_l_q[LAT];
            end
        end
    end
endmodule
